rgb_lane_sync_fifo: RTL and testbench

- Parametrised single-clock bank of LANES pixel-lane FIFOs plus one sideband (vs/hs/de) control FIFO.
- All lanes and the control FIFO are popped in lockstep through one valid/ready output, so a pixel group leaves only when every lane holds data.
- Sits between the LVDS lane deserialisers and the MIPI packetizer, in the same clock domain as both.
- Adds the following to the existing per-lane FIFOs: flush, sticky overflow and lane-skew error detection, and almost-full flags.

---
 rtl/rgb_fifo_pkg.sv | 26 ++
 rtl/sync_fifo_core.sv | 53 +++++
 rtl/rgb_lane_sync_fifo.sv | 176 +++++++++++++++++
 tb/tb_rgb_lane_sync_fifo.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_fifo_pkg.sv
// Shared types and helpers for the RGB lane FIFO bank: defaults, pointer level math,
// sticky error bit indices and the output-stage state encoding.
package rgb_fifo_pkg;

  localparam int unsigned LANES_DEF = 4;
  localparam int unsigned PTR_MAX_W = 32;

  localparam int unsigned ERR_OVF  = 0;
  localparam int unsigned ERR_SKEW = 1;
  localparam int unsigned ERR_W    = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HOLD  = 1'b1
  } out_state_t;

  // Occupancy of a circular buffer whose pointers are aw+1 bits wide.
  function automatic logic [PTR_MAX_W-1:0] fifo_level(input logic [PTR_MAX_W-1:0] wptr,
                                                      input logic [PTR_MAX_W-1:0] rptr,
                                                      input int unsigned          aw);
    logic [PTR_MAX_W-1:0] mask;
    mask = (PTR_MAX_W'(1) << (aw + 1)) - PTR_MAX_W'(1);
    return (wptr - rptr) & mask;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock circular-buffer FIFO with asynchronous head read, flush and level output.
module sync_fifo_core
  import rgb_fifo_pkg::*;
#(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          wen,
  input  logic [DW-1:0] wdata,
  input  logic          ren,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  localparam int unsigned DEPTH = 2**AW;
  localparam int unsigned PW    = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          wr_ok;

  // Full is judged on the pre-pop level, so a popped full FIFO still drops a write.
  assign wr_ok = wen && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (ren)   rptr <= rptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !flush) mem[wptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr[AW-1:0]];
  assign level = PW'(fifo_level(PTR_MAX_W'(wptr), PTR_MAX_W'(rptr), AW));
  assign full  = (level == PW'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/rgb_lane_sync_fifo.sv
// Lockstep bank of pixel-lane FIFOs plus a sideband control FIFO behind one valid/ready port.
// Optional build macro RGB_LANE_FIFO_LEVEL_EN exposes registered per-lane levels on O_lane_level.
module rgb_lane_sync_fifo
  import rgb_fifo_pkg::*;
#(
  parameter int unsigned LANES    = LANES_DEF,
  parameter int unsigned DW       = 16,
  parameter int unsigned AW       = 10,
  parameter int unsigned CW       = 8,
  parameter int unsigned CAW      = 6,
  parameter int unsigned AFULL_TH = 2**AW - 8,
  parameter int unsigned SKEW_MAX = 4
) (
  input  logic                   I_clk,
  input  logic                   I_rst_n,
  input  logic                   I_flush,
  input  logic [LANES-1:0]       I_lane_wren,
  input  logic [LANES*DW-1:0]    I_lane_data,
  input  logic                   I_ctrl_wren,
  input  logic [CW-1:0]          I_ctrl_data,
  output logic                   O_valid,
  input  logic                   I_ready,
  output logic [LANES*DW-1:0]    O_lane_data,
  output logic [CW-1:0]          O_ctrl_data,
  output logic [LANES-1:0]       O_lane_full,
  output logic [LANES-1:0]       O_lane_afull,
  output logic [LANES-1:0]       O_lane_empty,
  output logic                   O_ctrl_empty,
  output logic                   O_ovf_err,
  output logic                   O_skew_err,
`ifdef RGB_LANE_FIFO_LEVEL_EN
  output logic [LANES*(AW+1)-1:0] O_lane_level,
`endif
  input  logic                   I_err_clr
);

  localparam int unsigned LW  = AW + 1;
  localparam int unsigned CLW = CAW + 1;

  logic [LANES*DW-1:0] lane_head;
  logic [LANES*LW-1:0] lane_level;
  logic [LANES-1:0]    lane_full;
  logic [LANES-1:0]    lane_empty;
  logic [CW-1:0]       ctrl_head;
  logic [CLW-1:0]      ctrl_level;
  logic                ctrl_full;
  logic                ctrl_empty;

  out_state_t          state;
  out_state_t          state_nxt;
  logic                avail_c;
  logic                pop_c;
  logic [ERR_W-1:0]    err;
  logic [ERR_W-1:0]    err_ev_c;
  logic [LW-1:0]       lvl_max_c;
  logic [LW-1:0]       lvl_min_c;
  logic [LW-1:0]       lvl_tmp_c;
  logic                skew_c;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sync_fifo_core #(.DW(DW), .AW(AW)) u_lane (
      .clk   (I_clk),
      .rst_n (I_rst_n),
      .flush (I_flush),
      .wen   (I_lane_wren[g]),
      .wdata (I_lane_data[g*DW +: DW]),
      .ren   (pop_c),
      .rdata (lane_head[g*DW +: DW]),
      .full  (lane_full[g]),
      .empty (lane_empty[g]),
      .level (lane_level[g*LW +: LW])
    );
    assign O_lane_afull[g] = (lane_level[g*LW +: LW] >= LW'(AFULL_TH));
  end

  sync_fifo_core #(.DW(CW), .AW(CAW)) u_ctrl (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .flush (I_flush),
    .wen   (I_ctrl_wren),
    .wdata (I_ctrl_data),
    .ren   (pop_c),
    .rdata (ctrl_head),
    .full  (ctrl_full),
    .empty (ctrl_empty),
    .level (ctrl_level)
  );

  assign O_lane_full  = lane_full;
  assign O_lane_empty = lane_empty;
  assign O_ctrl_empty = ctrl_empty;
  assign avail_c      = (&(~lane_empty)) && (ctrl_level != '0);

  // Output stage: state register
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) state <= ST_EMPTY;
    else          state <= state_nxt;
  end

  // Output stage: next state and lockstep pop; flush overrides everything
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (avail_c) begin
          pop_c     = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (I_ready) begin
          if (avail_c) pop_c = 1'b1;
          else         state_nxt = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    if (I_flush) begin
      state_nxt = ST_EMPTY;
      pop_c     = 1'b0;
    end
  end

  assign O_valid = (state == ST_HOLD);

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      O_lane_data <= '0;
      O_ctrl_data <= '0;
    end else if (I_flush) begin
      O_lane_data <= '0;
      O_ctrl_data <= '0;
    end else if (pop_c) begin
      O_lane_data <= lane_head;
      O_ctrl_data <= ctrl_head;
    end
  end

  // Lane level spread; the control FIFO does not take part
  always_comb begin
    lvl_max_c = '0;
    lvl_min_c = '1;
    lvl_tmp_c = '0;
    for (int i = 0; i < LANES; i++) begin
      lvl_tmp_c = lane_level[i*LW +: LW];
      if (lvl_tmp_c > lvl_max_c) lvl_max_c = lvl_tmp_c;
      if (lvl_tmp_c < lvl_min_c) lvl_min_c = lvl_tmp_c;
    end
    skew_c = ((lvl_max_c - lvl_min_c) > LW'(SKEW_MAX));
  end

  always_comb begin
    err_ev_c           = '0;
    err_ev_c[ERR_OVF]  = (|(I_lane_wren & lane_full)) || (I_ctrl_wren && ctrl_full);
    err_ev_c[ERR_SKEW] = skew_c;
  end

  // Sticky errors: a new event beats a simultaneous clear; flush leaves them alone
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) err <= '0;
    else          err <= (err & ~{ERR_W{I_err_clr}}) | err_ev_c;
  end

  assign O_ovf_err  = err[ERR_OVF];
  assign O_skew_err = err[ERR_SKEW];

`ifdef RGB_LANE_FIFO_LEVEL_EN
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n)     O_lane_level <= '0;
    else if (I_flush) O_lane_level <= '0;
    else              O_lane_level <= lane_level;
  end
`endif

endmodule

// File: tb/tb_rgb_lane_sync_fifo.sv
// Randomized bench for rgb_lane_sync_fifo against a queue-based reference model.
module tb_rgb_lane_sync_fifo;

  localparam int LANES    = 4;
  localparam int DW       = 16;
  localparam int AW       = 10;
  localparam int CW       = 8;
  localparam int LW       = AW + 1;
  localparam int DEPTH    = 1024;
  localparam int CDEPTH   = 64;
  localparam int AFULL_TH = 1016;
  localparam int SKEW_MAX = 4;

  logic                  clk;
  logic                  rst_n;
  logic                  flush;
  logic [LANES-1:0]      lane_wren;
  logic [LANES*DW-1:0]   lane_data;
  logic                  ctrl_wren;
  logic [CW-1:0]         ctrl_data;
  logic                  ready;
  logic                  err_clr;
  logic                  O_valid;
  logic [LANES*DW-1:0]   O_lane_data;
  logic [CW-1:0]         O_ctrl_data;
  logic [LANES-1:0]      O_lane_full;
  logic [LANES-1:0]      O_lane_afull;
  logic [LANES-1:0]      O_lane_empty;
  logic                  O_ctrl_empty;
  logic                  O_ovf_err;
  logic                  O_skew_err;
`ifdef RGB_LANE_FIFO_LEVEL_EN
  logic [LANES*LW-1:0]   O_lane_level;
`endif

  rgb_lane_sync_fifo dut (
    .I_clk        (clk),
    .I_rst_n      (rst_n),
    .I_flush      (flush),
    .I_lane_wren  (lane_wren),
    .I_lane_data  (lane_data),
    .I_ctrl_wren  (ctrl_wren),
    .I_ctrl_data  (ctrl_data),
    .O_valid      (O_valid),
    .I_ready      (ready),
    .O_lane_data  (O_lane_data),
    .O_ctrl_data  (O_ctrl_data),
    .O_lane_full  (O_lane_full),
    .O_lane_afull (O_lane_afull),
    .O_lane_empty (O_lane_empty),
    .O_ctrl_empty (O_ctrl_empty),
    .O_ovf_err    (O_ovf_err),
    .O_skew_err   (O_skew_err),
`ifdef RGB_LANE_FIFO_LEVEL_EN
    .O_lane_level (O_lane_level),
`endif
    .I_err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  logic [DW-1:0]       lq [LANES][$];
  logic [CW-1:0]       cq [$];
  logic                m_valid;
  logic [LANES*DW-1:0] m_lane_data;
  logic [CW-1:0]       m_ctrl_data;
  logic                m_ovf;
  logic                m_skew;
  logic [LANES*LW-1:0] m_level;

  logic [LANES*DW-1:0] sb [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LANES; i++) lq[i].delete();
    cq.delete();
    m_valid = 1'b0; m_lane_data = '0; m_ctrl_data = '0;
    m_ovf = 1'b0; m_skew = 1'b0; m_level = '0;
  endtask

  // Applies one clock edge of the behavioural rules to the model
  task automatic model_edge();
    bit avail, pop, ovf_ev, skew_ev, cfull;
    bit [LANES-1:0] lfull;
    int mx, mn;
    avail = (cq.size() != 0);
    mx = 0; mn = DEPTH + 1;
    for (int i = 0; i < LANES; i++) begin
      if (lq[i].size() == 0) avail = 1'b0;
      lfull[i] = (lq[i].size() == DEPTH);
      if (lq[i].size() > mx) mx = lq[i].size();
      if (lq[i].size() < mn) mn = lq[i].size();
    end
    cfull   = (cq.size() == CDEPTH);
    pop     = !flush && avail && (!m_valid || ready);
    ovf_ev  = (ctrl_wren && cfull) || ((lane_wren & lfull) != '0);
    skew_ev = (mx - mn) > SKEW_MAX;
    m_ovf   = (m_ovf && !err_clr) || ovf_ev;
    m_skew  = (m_skew && !err_clr) || skew_ev;
    for (int i = 0; i < LANES; i++) m_level[i*LW +: LW] = flush ? '0 : LW'(lq[i].size());
    if (flush) begin
      for (int i = 0; i < LANES; i++) lq[i].delete();
      cq.delete();
      m_valid = 1'b0; m_lane_data = '0; m_ctrl_data = '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < LANES; i++) m_lane_data[i*DW +: DW] = lq[i].pop_front();
        m_ctrl_data = cq.pop_front();
        m_valid = 1'b1;
      end else if (m_valid && ready) begin
        m_valid = 1'b0;
      end
      for (int i = 0; i < LANES; i++)
        if (lane_wren[i] && !lfull[i]) lq[i].push_back(lane_data[i*DW +: DW]);
      if (ctrl_wren && !cfull) cq.push_back(ctrl_data);
    end
  endtask

  task automatic compare_all();
    logic [LANES-1:0] e_full, e_afull, e_empty;
    for (int i = 0; i < LANES; i++) begin
      e_full[i]  = (lq[i].size() == DEPTH);
      e_afull[i] = (lq[i].size() >= AFULL_TH);
      e_empty[i] = (lq[i].size() == 0);
    end
    check("valid",      64'(O_valid),      64'(m_valid));
    check("lane_data",  64'(O_lane_data),  64'(m_lane_data));
    check("ctrl_data",  64'(O_ctrl_data),  64'(m_ctrl_data));
    check("lane_full",  64'(O_lane_full),  64'(e_full));
    check("lane_afull", 64'(O_lane_afull), 64'(e_afull));
    check("lane_empty", 64'(O_lane_empty), 64'(e_empty));
    check("ctrl_empty", 64'(O_ctrl_empty), 64'(cq.size() == 0));
    check("ovf_err",    64'(O_ovf_err),    64'(m_ovf));
    check("skew_err",   64'(O_skew_err),   64'(m_skew));
`ifdef RGB_LANE_FIFO_LEVEL_EN
    check("lane_level", 64'(O_lane_level), 64'(m_level));
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    flush = 1'b0; lane_wren = '0; lane_data = '0;
    ctrl_wren = 1'b0; ctrl_data = '0; err_clr = 1'b0;
  endtask

  task automatic clean();
    idle_inputs();
    flush = 1'b1;
    step();
    flush = 1'b0; err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    int acc;
    int groups_in;
    logic [LANES*DW-1:0] grp;

    idle_inputs();
    ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;

    // Three lockstep groups with the consumer always ready
    ready = 1'b1;
    for (int s = 0; s < 5; s++) begin
      idle_inputs();
      if (s < 3) begin
        lane_wren = '1; ctrl_wren = 1'b1; ctrl_data = CW'(s);
        for (int i = 0; i < LANES; i++) lane_data[i*DW +: DW] = DW'((s << 8) | i);
      end
      step();
      check("dir_valid", 64'(O_valid), 64'((s >= 1 && s <= 3) ? 1 : 0));
      if (s >= 1 && s <= 3) check("dir_lane2", 64'(O_lane_data[2*DW +: DW]), 64'(((s - 1) << 8) | 2));
    end

    // Fill lane 0 to capacity, overflow once, then clear the sticky error
    clean();
    ready = 1'b0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      lane_wren = 4'b0001;
      lane_data = 64'($urandom);
      step();
      if (k == AFULL_TH - 1) check("afull_below", 64'(O_lane_afull[0]), 64'd0);
      if (k == AFULL_TH)     check("afull_at",    64'(O_lane_afull[0]), 64'd1);
    end
    check("ovf_set",   64'(O_ovf_err),      64'd1);
    check("full_lane0", 64'(O_lane_full[0]), 64'd1);
    idle_inputs();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("ovf_clr",   64'(O_ovf_err),  64'd0);
    check("skew_kept", 64'(O_skew_err), 64'd1);

    // Lane 1 alone: spread crosses the limit at level 5
    clean();
    for (int k = 1; k <= 6; k++) begin
      lane_wren = 4'b0010;
      lane_data = {$urandom, $urandom};
      step();
      check("skew_lane1", 64'(O_skew_err), 64'(k == 6));
      check("skew_novalid", 64'(O_valid), 64'd0);
    end

    // Random streaming with a toggling consumer; scoreboard tracks group order
    clean();
    ready = 1'b0; acc = 0; groups_in = 0;
    for (int c = 0; c < 12000 && (groups_in < 2000 || O_valid || cq.size() != 0); c++) begin
      idle_inputs();
      ready = ~ready;
      if (groups_in < 2000 && $urandom_range(0, 3) != 0 && cq.size() < CDEPTH) begin
        grp = {$urandom, $urandom};
        lane_wren = '1; lane_data = grp;
        ctrl_wren = 1'b1; ctrl_data = CW'($urandom);
        sb.push_back(grp);
        groups_in++;
      end
      if (O_valid && ready) begin
        if (sb.size() == 0) check("stream_extra", 64'd1, 64'd0);
        else                check("stream_data", 64'(O_lane_data), 64'(sb.pop_front()));
        acc++;
      end
      step();
    end
    idle_inputs();
    check("stream_count", 64'(acc), 64'd2000);

    // Flush with a held group and backlog; sticky skew must survive
    clean();
    ready = 1'b0;
    for (int k = 0; k < 11; k++) begin
      lane_wren = '1; lane_data = {$urandom, $urandom};
      ctrl_wren = 1'b1; ctrl_data = CW'($urandom);
      step();
    end
    idle_inputs();
    for (int k = 0; k < 5; k++) begin
      lane_wren = 4'b0001; lane_data = {$urandom, $urandom};
      step();
    end
    idle_inputs();
    step();
    check("pre_flush_valid", 64'(O_valid),    64'd1);
    check("pre_flush_skew",  64'(O_skew_err), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_valid", 64'(O_valid),      64'd0);
    check("flush_empty", 64'(O_lane_empty), 64'hf);
    check("flush_skew",  64'(O_skew_err),   64'd1);

`ifdef RGB_LANE_FIFO_LEVEL_EN
    clean();
    for (int k = 0; k < 7; k++) begin
      lane_wren = 4'b1000; lane_data = {$urandom, $urandom};
      step();
    end
    idle_inputs();
    step();
    check("level_lane3", 64'(O_lane_level[3*LW +: LW]), 64'd7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
